// File: rtl/apb4_master_arbiter_pkg.sv
// Shared types and constants for the APB4 multi-requester master.
package apb4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // PPROT bit meanings
    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

endpackage

// File: rtl/apb4_master_arbiter_if.sv
// APB4 bus bundle: master drives the request phase, slave returns the response.
interface apb4_if #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
) ();
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr
// (wrapping) wins, so the last winner drops to lowest priority.
module apb4_rr_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      ptr,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  any
);

    // scan ptr+1 .. ptr+REQUESTERS and keep the first hit
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            j = (int'(ptr) + k) % REQUESTERS;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb4_master_arbiter.sv
// APB4 master shared by several requesters with round-robin arbitration.
// Optional ACCESS watchdog enabled by defining APB4_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | bus idle, arbitrate among eligible requesters
// SETUP  | PSEL=1, PENABLE=0, payload presented
// ACCESS | PSEL=1, PENABLE=1, waiting for PREADY (or watchdog)
module apb4_master_arbiter
    import apb4_arb_pkg::*;
#(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32,
    parameter int REQUESTERS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [REQUESTERS-1:0]            req_i,
    input  logic [REQUESTERS-1:0]            write_i,
    input  logic [REQUESTERS*PADDR_SIZE-1:0] addr_i,
    input  logic [REQUESTERS*PDATA_SIZE-1:0] wdata_i,
    input  logic [REQUESTERS*PDATA_SIZE/8-1:0] strb_i,
    input  logic [REQUESTERS*3-1:0]          prot_i,
    output logic [REQUESTERS-1:0]            done_o,
    output logic [PDATA_SIZE-1:0]            rdata_o,
    output logic                             err_o,
    apb4_if.master                           apb
);

    localparam int IDX_W  = $clog2(REQUESTERS);
    localparam int STRB_W = PDATA_SIZE / 8;

    apb_state_e state, state_nxt;

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      cur;
    logic [REQUESTERS-1:0] eligible;
    logic [REQUESTERS-1:0] arb_grant;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;

    logic                  psel;
    logic                  penable;
    logic                  launch;
    logic                  xfer_end;
    logic                  xfer_timeout;

    logic                  pwrite_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic [PDATA_SIZE-1:0] pwdata_q;
    logic [STRB_W-1:0]     pstrb_q;
    logic [2:0]            pprot_q;

    // a requester whose done pulse is visible this cycle is about to drop req
    assign eligible = req_i & ~done_o;

    apb4_rr_arbiter #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_rr (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

`ifdef APB4_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;

    assign xfer_timeout = (state == ACCESS) && !apb.PREADY && (wait_cnt == TO_W'(TIMEOUT));

    // count ACCESS cycles stalled by PREADY=0, restarting for every transfer
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !apb.PREADY && !xfer_timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // TIMEOUT is never negative, so without the watchdog this is constant 0
    assign xfer_timeout = (TIMEOUT < 0);
`endif

    assign xfer_end = (state == ACCESS) && (apb.PREADY || xfer_timeout);

    // state register
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (xfer_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus controls follow the registered state directly
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        launch  = 1'b0;
        case (state)
            IDLE:    launch = arb_any;
            SETUP:   psel = 1'b1;
            ACCESS:  begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // payload capture at grant, response capture and pointer update at completion
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ptr      <= IDX_W'(REQUESTERS - 1);
            cur      <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            pprot_q  <= '0;
            done_o   <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            done_o <= '0;
            if (launch) begin
                cur      <= arb_idx;
                pwrite_q <= write_i[arb_idx];
                paddr_q  <= addr_i[arb_idx*PADDR_SIZE +: PADDR_SIZE];
                pprot_q  <= prot_i[arb_idx*3 +: 3];
                pwdata_q <= write_i[arb_idx] ? wdata_i[arb_idx*PDATA_SIZE +: PDATA_SIZE] : '0;
                pstrb_q  <= write_i[arb_idx] ? strb_i[arb_idx*STRB_W +: STRB_W] : '0;
            end
            if (xfer_end) begin
                done_o[cur] <= 1'b1;
                rdata_o     <= (pwrite_q || !apb.PREADY) ? '0 : apb.PRDATA;
                err_o       <= apb.PREADY ? apb.PSLVERR : 1'b1;
                ptr         <= cur;
            end
        end
    end

    assign apb.PSEL    = psel;
    assign apb.PENABLE = penable;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = pprot_q;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Scoreboard bench for apb4_master_arbiter: a round-robin reference model
// predicts the order and result of every transfer; a monitor checks the bus.
module tb_apb4_master_arbiter;
    import apb4_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        int          idx;
        bit          write;
        logic [15:0] addr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        bit          err;
        int          waits;
        int          len;
    } exp_t;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic [N-1:0]   req_i, write_i;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*4-1:0] strb_i;
    logic [N*3-1:0] prot_i;
    logic [N-1:0]   done_o;
    logic [DW-1:0]  rdata_o;
    logic           err_o;

    apb4_if #(.PADDR_SIZE(AW), .PDATA_SIZE(DW)) apb ();

    apb4_master_arbiter #(
        .PADDR_SIZE(AW), .PDATA_SIZE(DW), .REQUESTERS(N), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_i(req_i), .write_i(write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i), .prot_i(prot_i),
        .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .apb(apb)
    );

    always #5 PCLK = ~PCLK;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   model_last;
    bit   mon_en = 1'b0;
    bit   stall_all = 1'b0;
    bit   prev_psel;
    int   psel_len;
    logic [15:0] last_addr;
    logic        last_write;
    logic [2:0]  last_prot;
    logic [31:0] last_wdata;
    logic [3:0]  last_strb;

    bit          p_wr[N];
    logic [15:0] p_addr[N];
    logic [31:0] p_wdata[N];
    logic [3:0]  p_strb[N];
    logic [2:0]  p_prot[N];
    int          p_waits[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // slave read-data and error rules
    function automatic logic [31:0] rd_fn(input logic [15:0] a);
        if (a == 16'h0100) return 32'h1234_5678;
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic bit err_fn(input logic [15:0] a);
        return a[15:12] == 4'hE;
    endfunction

    task automatic rand_payload(input int i);
        p_wr[i]    = 1'($urandom % 2);
        p_addr[i]  = 16'($urandom);
        p_wdata[i] = $urandom;
        p_strb[i]  = 4'($urandom);
        p_prot[i]  = 3'($urandom);
        p_waits[i] = $urandom_range(0, 3);
    endtask

    task automatic clear_bench_state();
        model_last = N - 1;
        last_addr  = '0;
        last_write = 1'b0;
        last_prot  = '0;
        last_wdata = '0;
        last_strb  = '0;
        prev_psel  = 1'b0;
    endtask

    // predict the grant sequence for a set of simultaneous requests, then run it
    task automatic launch(input logic [N-1:0] mask);
        logic [N-1:0] pend;
        int   budget;
        exp_t e;
        pend = mask;
        while (pend != 0) begin
            int  pick;
            bit  found;
            found = 1'b0;
            pick  = 0;
            for (int k = 1; k <= N; k++) begin
                int jj;
                jj = (model_last + k) % N;
                if (!found && pend[jj]) begin
                    found = 1'b1;
                    pick  = jj;
                end
            end
            e.idx    = pick;
            e.write  = p_wr[pick];
            e.addr   = p_addr[pick];
            e.pwdata = p_wr[pick] ? p_wdata[pick] : 32'h0;
            e.pstrb  = p_wr[pick] ? p_strb[pick] : 4'h0;
            e.prot   = p_prot[pick];
            e.waits  = p_waits[pick];
            e.rdata  = p_wr[pick] ? 32'h0 : rd_fn(p_addr[pick]);
            e.err    = err_fn(p_addr[pick]);
            e.len    = p_waits[pick] + 2;
`ifdef APB4_ARB_TIMEOUT_EN
            if (p_waits[pick] > TO) begin
                e.rdata = 32'h0;
                e.err   = 1'b1;
                e.len   = TO + 2;
            end
`endif
            exp_q.push_back(e);
            model_last = pick;
            pend[pick] = 1'b0;
        end
        @(negedge PCLK);
        for (int i = 0; i < N; i++) begin
            write_i[i]         = p_wr[i];
            addr_i[i*AW +: AW] = p_addr[i];
            wdata_i[i*DW +: DW] = p_wdata[i];
            strb_i[i*4 +: 4]   = p_strb[i];
            prot_i[i*3 +: 3]   = p_prot[i];
        end
        req_i  = mask;
        budget = 0;
        while (req_i != 0 && budget < 500) begin
            @(negedge PCLK);
            req_i = req_i & ~done_o;
            budget++;
        end
        if (req_i != 0) begin
            chk("launch_completion", 64'(req_i), 64'h0);
            req_i = '0;
            mon_en = 1'b0;
            PRESET = 1'b1;
            repeat (2) @(negedge PCLK);
            PRESET = 1'b0;
            exp_q.delete();
            clear_bench_state();
            mon_en = 1'b1;
        end
        @(negedge PCLK);
    endtask

    // park a transfer in ACCESS, then reset it away
    task automatic stall_then_reset(input logic [N-1:0] mask, input int hold);
        int dn;
        mon_en    = 1'b0;
        stall_all = 1'b1;
        dn        = 0;
        @(negedge PCLK);
        for (int i = 0; i < N; i++) begin
            write_i[i]          = p_wr[i];
            addr_i[i*AW +: AW]  = p_addr[i];
            wdata_i[i*DW +: DW] = p_wdata[i];
            strb_i[i*4 +: 4]    = p_strb[i];
            prot_i[i*3 +: 3]    = p_prot[i];
        end
        req_i = mask;
        repeat (hold) begin
            @(negedge PCLK);
            if (done_o != 0) dn++;
        end
        chk("stalled_psel", 64'(apb.PSEL), 64'h1);
        chk("stalled_penable", 64'(apb.PENABLE), 64'h1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_mid_psel", 64'(apb.PSEL), 64'h0);
        chk("rst_mid_penable", 64'(apb.PENABLE), 64'h0);
        chk("rst_mid_done", 64'(done_o), 64'h0);
        chk("rst_mid_paddr", 64'(apb.PADDR), 64'h0);
        req_i = '0;
        repeat (2) begin
            @(negedge PCLK);
            if (done_o != 0) dn++;
        end
        chk("no_done_on_stall", 64'(dn), 64'h0);
        PRESET    = 1'b0;
        stall_all = 1'b0;
        clear_bench_state();
        mon_en = 1'b1;
    endtask

    // APB slave: per-transfer wait states, address-derived response
    initial begin
        int wcnt;
        wcnt = 0;
        apb.PREADY  = 1'b0;
        apb.PRDATA  = '0;
        apb.PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (apb.PSEL && !apb.PENABLE) begin
                wcnt = stall_all ? (1 << 30) : ((exp_q.size() != 0) ? exp_q[0].waits : 0);
                apb.PREADY  = 1'b0;
                apb.PRDATA  = $urandom;
                apb.PSLVERR = 1'($urandom % 2);
            end else if (apb.PSEL && apb.PENABLE) begin
                if (wcnt > 0) begin
                    wcnt--;
                    apb.PREADY  = 1'b0;
                    apb.PRDATA  = $urandom;
                    apb.PSLVERR = 1'($urandom % 2);
                end else begin
                    apb.PREADY  = 1'b1;
                    apb.PSLVERR = err_fn(apb.PADDR);
                    apb.PRDATA  = apb.PWRITE ? $urandom : rd_fn(apb.PADDR);
                end
            end else begin
                apb.PREADY = 1'b0;
            end
        end
    end

    // monitor: setup payload, hold behaviour, completion results
    always @(negedge PCLK) begin
        exp_t m;
        if (mon_en) begin
            if (apb.PSEL && !apb.PENABLE) begin
                chk("idle_gap", 64'(prev_psel), 64'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_setup", 64'(apb.PSEL), 64'h0);
                end else begin
                    m = exp_q[0];
                    chk("setup_paddr", 64'(apb.PADDR), 64'(m.addr));
                    chk("setup_pwrite", 64'(apb.PWRITE), 64'(m.write));
                    chk("setup_pwdata", 64'(apb.PWDATA), 64'(m.pwdata));
                    chk("setup_pstrb", 64'(apb.PSTRB), 64'(m.pstrb));
                    chk("setup_pprot", 64'(apb.PPROT), 64'(m.prot));
                    last_addr  = m.addr;
                    last_write = m.write;
                    last_prot  = m.prot;
                    last_wdata = m.pwdata;
                    last_strb  = m.pstrb;
                end
                psel_len = 1;
            end else begin
                chk("hold_paddr", 64'(apb.PADDR), 64'(last_addr));
                chk("hold_pwrite", 64'(apb.PWRITE), 64'(last_write));
                chk("hold_pprot", 64'(apb.PPROT), 64'(last_prot));
                if (apb.PSEL) begin
                    psel_len++;
                    chk("access_pwdata", 64'(apb.PWDATA), 64'(last_wdata));
                    chk("access_pstrb", 64'(apb.PSTRB), 64'(last_strb));
                end else begin
                    chk("idle_penable", 64'(apb.PENABLE), 64'h0);
                end
            end
            if (done_o != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done_o), 64'h0);
                end else begin
                    m = exp_q.pop_front();
                    chk("done_onehot", 64'(done_o), 64'(1) << m.idx);
                    chk("done_rdata", 64'(rdata_o), 64'(m.rdata));
                    chk("done_err", 64'(err_o), 64'(m.err));
                    chk("psel_cycles", 64'(psel_len), 64'(m.len));
                    chk("done_psel_low", 64'(apb.PSEL), 64'h0);
                end
            end
            prev_psel = apb.PSEL;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET  = 1'b1;
        req_i   = '0;
        write_i = '0;
        addr_i  = '0;
        wdata_i = '0;
        strb_i  = '0;
        prot_i  = '0;
        clear_bench_state();
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 64'(apb.PSEL), 64'h0);
        chk("rst_penable", 64'(apb.PENABLE), 64'h0);
        chk("rst_pwrite", 64'(apb.PWRITE), 64'h0);
        chk("rst_paddr", 64'(apb.PADDR), 64'h0);
        chk("rst_pwdata", 64'(apb.PWDATA), 64'h0);
        chk("rst_pstrb", 64'(apb.PSTRB), 64'h0);
        chk("rst_pprot", 64'(apb.PPROT), 64'h0);
        chk("rst_done", 64'(done_o), 64'h0);
        chk("rst_rdata", 64'(rdata_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        PRESET = 1'b0;
        mon_en = 1'b1;

        // fairness: everyone at once, then alternating pair twice
        for (int i = 0; i < N; i++) begin
            rand_payload(i);
            p_waits[i] = 0;
        end
        launch(4'b1111);
        launch(4'b0101);
        launch(4'b0101);

        // single write, zero wait
        p_wr[0] = 1'b1; p_addr[0] = 16'h0010; p_wdata[0] = 32'hDEAD_BEEF;
        p_strb[0] = 4'hF; p_prot[0] = PPROT_PRIVILEGED; p_waits[0] = 0;
        launch(4'b0001);

        // read with three wait states
        p_wr[2] = 1'b0; p_addr[2] = 16'h0100; p_wdata[2] = 32'hFFFF_FFFF;
        p_strb[2] = 4'hF; p_prot[2] = PPROT_NONSECURE | PPROT_INSTRUCTION; p_waits[2] = 3;
        launch(4'b0100);

        // slave error, then a clean transfer
        p_wr[3] = 1'b1; p_addr[3] = 16'hE004; p_wdata[3] = 32'h0BAD_F00D;
        p_strb[3] = 4'h3; p_prot[3] = 3'b000; p_waits[3] = 1;
        launch(4'b1000);
        p_addr[3] = 16'h0204; p_waits[3] = 0;
        launch(4'b1000);

`ifdef APB4_ARB_TIMEOUT_EN
        rand_payload(1);
        p_wr[1] = 1'b0; p_addr[1] = 16'h0020; p_waits[1] = 1000;
        launch(4'b0010);
`else
        rand_payload(0);
        p_wr[0] = 1'b1; p_addr[0] = 16'h0030;
        stall_then_reset(4'b0001, 100);
`endif

        // reset during ACCESS, then pointer restarts at requester 0
        for (int i = 0; i < N; i++) rand_payload(i);
        p_addr[1] = 16'h0040;
        stall_then_reset(4'b0010, 5);
        for (int i = 0; i < N; i++) begin
            rand_payload(i);
            p_waits[i] = 0;
        end
        launch(4'b0110);

        repeat (40) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) rand_payload(i);
            launch(mask);
        end

        repeat (3) @(negedge PCLK);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb4_master_arbiter.md
Name: apb4_master_arbiter

Overview:
- Synthesizable APB4 master that shares one APB4 bus between REQUESTERS independent on-chip requesters.
- Each requester issues single read/write commands over a level req / pulse done handshake.
- Round-robin arbitration; drives the standard SETUP/ACCESS sequence and returns PRDATA/PSLVERR to the winner.
- Sits between CPU/DMA-side agents and an APB4 decoder/slave fabric; the BFM masters remain testbench-only.

Parameters:
- PADDR_SIZE, 16, APB address width
- PDATA_SIZE, 32, APB data width (multiple of 8)
- REQUESTERS, 4, number of requesters (2..16)
- TIMEOUT, 255, ACCESS wait-cycle limit (used only with the optional feature)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- req_i  in  REQUESTERS  per-requester command request
- write_i  in  REQUESTERS  1=write
- addr_i  in  REQUESTERS*PADDR_SIZE  flattened addresses
- wdata_i  in  REQUESTERS*PDATA_SIZE  flattened write data
- strb_i  in  REQUESTERS*PDATA_SIZE/8  flattened byte strobes
- prot_i  in  REQUESTERS*3  flattened PPROT
- done_o  out  REQUESTERS  one-cycle completion pulse
- rdata_o  out  PDATA_SIZE  read data, valid with done_o
- err_o  out  1  PSLVERR/timeout, valid with done_o
- PSEL, PENABLE, PWRITE  out  1  APB4 controls
- PADDR  out  PADDR_SIZE
- PWDATA  out  PDATA_SIZE
- PSTRB  out  PDATA_SIZE/8
- PPROT  out  3
- PRDATA  in  PDATA_SIZE
- PREADY, PSLVERR  in  1

Behaviour:
- Reset (PRESET=1 at PCLK edge): all outputs 0; state IDLE; RR pointer makes requester 0 highest priority. Reset mid-transfer aborts it: no done_o, PSEL/PENABLE 0 next cycle.
- Requester rule: hold req_i and payload stable from assertion until done_o[n]; drop req_i the cycle done_o[n] is seen.
- Registered outputs. FSM:
  - IDLE: eligible = req_i & ~done_o. If any eligible, grant first eligible at or after pointer+1 (mod REQUESTERS; after reset, 0 first). Latch payload onto APB outputs, PSEL=1, PENABLE=0 -> SETUP.
  - SETUP: PENABLE=1 -> ACCESS (unconditional).
  - ACCESS:
    - PREADY=0: hold all outputs.
    - PREADY=1 at edge: rdata_o<=PRDATA (0 on writes), err_o<=PSLVERR, done_o[grant]<=1 for one cycle, PSEL=PENABLE=0, pointer<=grant -> IDLE.
- Minimum 3 cycles per transfer, idle cycle always between transfers.
- Reads: PSTRB=0, PWDATA=0.
- PADDR/PWRITE/PPROT hold last value while idle.
- Simultaneous requests: strict RR, no starvation.
- A requester asserting req during another's transfer waits its turn.
- req_i dropped before done_o: illegal; transfer still completes and done_o still pulses.

Optional Feature:
- Macro APB4_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT, terminate as if PREADY=1 with err_o=1, rdata_o=0; PSEL/PENABLE drop.
  - Counter width $clog2(TIMEOUT+1).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT ignored.

Decomposition:
- Package apb4_arb_pkg: state enum typedef (IDLE, SETUP, ACCESS); PPROT bit constants (privileged, nonsecure, instruction).
- Sub-module apb4_rr_arbiter: combinational round-robin select (req vector, pointer -> one-hot grant + index). Main module holds FSM, pointer, payload registers.

Test Plan:
- Write: req_i[0]=1, addr 0x0010, data 0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL high 2 cycles, PENABLE 2nd only, PWDATA=0xDEADBEEF, done_o=0001 one cycle later, err_o=0.
- Read: req_i[2], addr 0x0100, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> ACCESS lasts 4 cycles, PSTRB=0, done_o=0100, rdata_o=0x12345678.
- Fairness: req_i=1111 held after reset, each dropped on its done -> grants 0,1,2,3, each 3 cycles + idle gap. Then req_i=0101 twice -> 0,2,0,2.
- Error: write with PSLVERR=1 at completion -> err_o=1 with done_o; next transfer err_o=0.
- Reset mid-ACCESS: PRESET=1 with PREADY=0 -> next cycle PSEL=PENABLE=0, no done_o. After release, req_i=0110 -> requester 1 first.
- Timeout: TIMEOUT=8, PREADY stuck 0.
  - With APB4_ARB_TIMEOUT_EN: done_o + err_o=1 after 8 ACCESS wait cycles.
  - Without: PSEL still 1 after 100 cycles.
